// File: rtl/m_wb_uarttx.sv
// Wishbone-classic slave UART transmitter (8N1, LSB first) with a one-byte
// holding register, or a circular FIFO when UARTTX_FIFO_EN is defined.
module m_wb_uarttx #(
  parameter int unsigned BAUDDIV   = 286,
  parameter int unsigned DIVWIDTH  = 16,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  input  logic       ADR_I,
  input  logic [7:0] DAT_I,
  input  logic       SEL_I,
  output logic [7:0] DAT_O,
  output logic       ACK_O,
  output logic       txd,
  output logic       txirq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam logic [DIVWIDTH-1:0] BAUD_LAST = DIVWIDTH'(BAUDDIV - 1);
  localparam logic [DIVWIDTH-1:0] BAUD_ONE  = DIVWIDTH'(1);

  state_t              state_q, state_d;
  logic [DIVWIDTH-1:0] baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                overrun_q;

  logic                buf_empty;
  logic                buf_full;
  logic [7:0]          buf_head;
  logic                pop;
  logic                push;
  logic                wr;
  logic                wr_stat;
  logic                busy;

  // Wishbone classic, zero wait states: every cycle with CYC_I & STB_I is
  // acknowledged in the same cycle; writes take effect on that rising edge.
  assign ACK_O   = CYC_I & STB_I;
  assign wr      = ACK_O & WE_I & SEL_I & ~ADR_I;
  assign wr_stat = ACK_O & WE_I & SEL_I & ADR_I;

  // A write into a full buffer still lands if the shifter frees a slot
  // on the same edge.
  assign push = wr & (~buf_full | pop);

`ifdef UARTTX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFODEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0] mem_q [FIFODEPTH];
  logic [AW:0] wp_q, rp_q;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop)  rp_q <= rp_q + PTR_ONE;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wp_q[AW-1:0]] <= DAT_I;
  end

  // Extra pointer MSB distinguishes full from empty when indices coincide.
  assign buf_empty = (wp_q == rp_q);
  assign buf_full  = ((wp_q ^ rp_q) == {1'b1, {AW{1'b0}}});
  assign buf_head  = mem_q[rp_q[AW-1:0]];
`else
  logic [7:0] hold_q;
  logic       full_q;
  logic [4:0] unused_fifodepth;

  // FIFODEPTH only matters in the FIFO build.
  assign unused_fifodepth = 5'(FIFODEPTH);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      hold_q <= 8'h00;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        hold_q <= DAT_I;
        full_q <= 1'b1;
      end else if (pop) begin
        full_q <= 1'b0;
      end
    end
  end

  assign buf_empty = ~full_q;
  assign buf_full  = full_q;
  assign buf_head  = hold_q;
`endif

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      overrun_q <= 1'b0;
    end else if (wr & buf_full & ~pop) begin
      overrun_q <= 1'b1;
    end else if (wr_stat & DAT_I[2]) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shreg_q <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  // bit_q tracks the frame slot: 0 start, 1..8 data, 9 stop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!buf_empty) begin
          pop     = 1'b1;
          shreg_d = buf_head;
          state_d = ST_START;
          baud_d  = BAUD_LAST;
          bit_d   = 4'd0;
        end
      end
      ST_START: begin
        if (baud_q == '0) begin
          state_d = ST_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = 4'd1;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_q == '0) begin
          shreg_d = {1'b1, shreg_q[7:1]};
          baud_d  = BAUD_LAST;
          if (bit_q == 4'd8) begin
            state_d = ST_STOP;
            bit_d   = 4'd9;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_q == '0) begin
          bit_d = 4'd0;
          // Chain the next byte straight into a start bit, no idle gap.
          if (!buf_empty) begin
            pop     = 1'b1;
            shreg_d = buf_head;
            state_d = ST_START;
            baud_d  = BAUD_LAST;
          end else begin
            state_d = ST_IDLE;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state_q)
      ST_START: txd = 1'b0;
      ST_DATA:  txd = shreg_q[0];
      default:  txd = 1'b1;
    endcase
  end

  assign busy  = (state_q != ST_IDLE);
  assign txirq = buf_empty & ~busy;
  assign DAT_O = ADR_I ? {4'b0000, buf_empty, overrun_q, buf_full, busy} : 8'h00;

endmodule

// File: tb/tb_m_wb_uarttx.sv
// Bench for m_wb_uarttx (BAUDDIV=4): directed steps plus random writes checked
// against a timestamp model of frames; build with UARTTX_FIFO_EN for FIFO mode.
module tb_m_wb_uarttx;

  localparam int BD = 4;
  localparam int FL = 10 * BD;
`ifdef UARTTX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       RST_N_I;
  logic       CYC_I, STB_I, WE_I, ADR_I, SEL_I;
  logic [7:0] DAT_I;
  logic [7:0] DAT_O;
  logic       ACK_O, txd, txirq;

  m_wb_uarttx #(.BAUDDIV(BD), .DIVWIDTH(16), .FIFODEPTH(4)) dut (
    .CLK_I  (clk),
    .RST_N_I(RST_N_I),
    .CYC_I  (CYC_I),
    .STB_I  (STB_I),
    .WE_I   (WE_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .SEL_I  (SEL_I),
    .DAT_O  (DAT_O),
    .ACK_O  (ACK_O),
    .txd    (txd),
    .txirq  (txirq)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard: accepted bytes and the edge at which each frame starts
  logic [7:0] exp_q[$];
  int         pop_t[$];
  bit         m_ovr;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  function automatic void model_reset();
    exp_q.delete();
    pop_t.delete();
    m_ovr = 1'b0;
  endfunction

  // Write landing at edge w: accepted if fewer than CAP bytes wait after w;
  // its frame starts one edge later, or when the previous frame ends.
  function automatic void model_write(int w, logic [7:0] d);
    int cnt = 0;
    int p;
    foreach (pop_t[j]) if (pop_t[j] > w) cnt++;
    if (cnt < CAP) begin
      p = w + 1;
      if (pop_t.size() > 0 && pop_t[pop_t.size()-1] + FL > p) p = pop_t[pop_t.size()-1] + FL;
      pop_t.push_back(p);
      exp_q.push_back(d);
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  function automatic bit m_busy(int e);
    foreach (pop_t[k]) if (e >= pop_t[k] && e < pop_t[k] + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_cnt(int e);
    int c = 0;
    foreach (pop_t[k]) if (pop_t[k] > e) c++;
    return c;
  endfunction

  function automatic logic m_txd(int e);
    int idx;
    foreach (pop_t[k]) begin
      if (e >= pop_t[k] && e < pop_t[k] + FL) begin
        idx = (e - pop_t[k]) / BD;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return exp_q[k][idx-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] m_status(int e);
    int c;
    c = m_cnt(e);
    return {4'b0000, c == 0, m_ovr, c == CAP, m_busy(e)};
  endfunction

  // cycle monitor against the model, sampled on the falling edge
  int         txd_err = 0, st_err = 0, irq_err = 0, busy_cyc = 0;
  logic [7:0] mon_es;
  always @(negedge clk) begin
    mon_es = ADR_I ? m_status(cyc) : 8'h00;
    if (txd !== m_txd(cyc)) txd_err++;
    if (DAT_O !== mon_es) st_err++;
    if (txirq !== (m_cnt(cyc) == 0 && !m_busy(cyc))) irq_err++;
    if (ADR_I && DAT_O[0]) busy_cyc++;
  end

  int b_txd, b_st, b_irq, b_busy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic win_begin();
    b_txd  = txd_err;
    b_st   = st_err;
    b_irq  = irq_err;
    b_busy = busy_cyc;
  endtask

  task automatic win_end(input string tag);
    check({tag, "_txd_errs"}, 64'(txd_err - b_txd), 64'd0);
    check({tag, "_stat_errs"}, 64'(st_err - b_st), 64'd0);
    check({tag, "_irq_errs"}, 64'(irq_err - b_irq), 64'd0);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_write(input logic adr, input logic [7:0] dat, input logic sel);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    ADR_I = adr;  DAT_I = dat;  SEL_I = sel;
    @(posedge clk);
    #1;
    if (sel) begin
      if (!adr) model_write(cyc, dat);
      else if (dat[2]) m_ovr = 1'b0;
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = 1'b1; SEL_I = 1'b0;
  endtask

  logic [63:0] obs, expv;
  logic [9:0]  pat;
  int          gap, r;

  initial begin
    RST_N_I = 1'b1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    ADR_I = 1'b1; DAT_I = 8'h00; SEL_I = 1'b0;
    model_reset();
    #1 RST_N_I = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_txirq", 64'(txirq), 64'd1);
    check("rst_status", 64'(DAT_O), 64'h08);
    RST_N_I = 1'b1;
    @(posedge clk);
    #1;

    // idle status read, combinational ack
    CYC_I = 1'b1; STB_I = 1'b1;
    #1;
    check("rd_ack", 64'(ACK_O), 64'd1);
    check("rd_status", 64'(DAT_O), 64'h08);
    STB_I = 1'b0;
    #1;
    check("rd_nostb_ack", 64'(ACK_O), 64'd0);
    CYC_I = 1'b0;

    // single frame, exact waveform
    win_begin();
    wb_write(1'b0, 8'hA5, 1'b1);
    @(negedge clk);
    obs = '0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      obs[i] = txd;
    end
    pat = {1'b1, 8'hA5, 1'b0};
    expv = '0;
    for (int i = 0; i < FL; i++) expv[i] = pat[i / BD];
    check("a5_wave", obs, expv);
    @(negedge clk);
    check("a5_txirq_after", 64'(txirq), 64'd1);
    check("a5_busy_cycles", 64'(busy_cyc - b_busy), 64'(FL));
    win_end("a5");
    @(posedge clk);
    #1;

    // back-to-back frames
    win_begin();
    wb_write(1'b0, 8'h55, 1'b1);
    tick(10);
    wb_write(1'b0, 8'h0F, 1'b1);
    tick(2 * FL + 10);
    check("b2b_status", 64'(DAT_O), 64'h08);
    win_end("b2b");

    // byte-lane select low: write ignored
    win_begin();
    wb_write(1'b0, 8'h99, 1'b0);
    tick(5);
    check("sel0_txd", 64'(txd), 64'd1);
    check("sel0_status", 64'(DAT_O), 64'h08);
    win_end("sel0");

    // overflow, sticky overrun, write-1-to-clear
    win_begin();
    for (int k = 0; k < CAP + 2; k++) wb_write(1'b0, 8'($urandom_range(0, 255)), 1'b1);
    #1;
    check("ovf_status_in_frame", 64'(DAT_O), 64'h07);
    tick((CAP + 1) * FL + 10);
    check("ovf_sticky", 64'(DAT_O), 64'h0C);
    wb_write(1'b1, 8'h04, 1'b1);
    check("ovf_cleared", 64'(DAT_O), 64'h08);
    win_end("ovf");

    // reset during data bit 3 (a 0 bit of 8'hC3), then a clean frame
    win_begin();
    wb_write(1'b0, 8'hC3, 1'b1);
    tick(1 + BD + 3 * BD);
    #2;
    check("pre_rst_txd", 64'(txd), 64'd0);
    RST_N_I = 1'b0;
    model_reset();
    #1;
    check("midrst_txd", 64'(txd), 64'd1);
    check("midrst_status", 64'(DAT_O), 64'h08);
    check("midrst_txirq", 64'(txirq), 64'd1);
    repeat (2) @(negedge clk);
    RST_N_I = 1'b1;
    @(posedge clk);
    #1;
    wb_write(1'b0, 8'h3C, 1'b1);
    tick(FL + 5);
    check("postrst_status", 64'(DAT_O), 64'h08);
    win_end("rst_mid");

    // random writes, gaps, status clears and deselected lanes
    win_begin();
    repeat (40) begin
      gap = $urandom_range(0, 3 * FL / 2);
      r   = $urandom_range(0, 9);
      if (r == 0) wb_write(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      else        wb_write(1'b0, 8'($urandom_range(0, 255)), r != 1);
      tick(gap);
    end
    tick((CAP + 2) * FL);
    win_end("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
